// File: rtl/dut_pipe.sv
// dut_pipe: multi-channel elastic delay pipeline with valid/ready handshakes.
// A chain of DEPTH register stages. Each stage advances when the stage ahead
// of it is empty or is itself advancing, so bubbles collapse under
// backpressure. Also provides a synchronous flush, a registered occupancy
// count and a saturating count of output transfers.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flush       synchronous clear of all stage valid bits
//   in_valid    upstream word valid
//   in_ready    pipeline can accept a word this cycle
//   in_data     upstream word; channel c is at [c*WIDTH +: WIDTH]
//   out_valid   last stage holds a word (suppressed while flushing)
//   out_ready   downstream accepts
//   out_data    last stage word
//   occupancy   number of valid stages
//   xfer_count  output transfers since reset, saturating
module dut_pipe #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*WIDTH-1:0]    out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             xfer_count
);

    localparam int unsigned DW    = CHANNELS * WIDTH;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] adv;
    logic [DW-1:0]    data_q [DEPTH];
    logic [OCC_W-1:0] occ_d;
    logic             out_xfer;

    // Advance chain from the output back to the input; a running carry keeps
    // the chain free of self-dependent vector bits.
    always_comb begin
        logic carry;
        adv   = '0;
        carry = !valid_q[DEPTH-1] | out_ready;
        adv[DEPTH-1] = carry;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            carry  = !valid_q[i] | carry;
            adv[i] = carry;
        end
    end

    // Handshake outputs; flush and reset both block every transfer.
    assign in_ready  = adv[0] & !flush & rst_n;
    assign out_valid = valid_q[DEPTH-1] & !flush;
    assign out_data  = data_q[DEPTH-1];
    assign out_xfer  = out_valid & out_ready;

    // Next valid vector and its population count.
    always_comb begin
        valid_d = valid_q;
        occ_d   = '0;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i]) begin
                    valid_d[i] = valid_q[i-1];
                end
            end
            if (adv[0]) begin
                valid_d[0] = in_valid;
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // Stage registers, occupancy and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            occupancy  <= '0;
            xfer_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            occupancy <= occ_d;
            // Data registers hold across a flush; only valid bits clear.
            if (!flush) begin
                for (int i = 1; i < int'(DEPTH); i++) begin
                    if (adv[i]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
                if (adv[0] && in_valid) begin
                    data_q[0] <= in_data;
                end
            end
            if (out_xfer && (xfer_count != CNT_MAX)) begin
                xfer_count <= xfer_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dut_pipe.sv
// tb_dut_pipe: self-checking bench for dut_pipe (DEPTH=4, 2x8-bit, CNT_W=3).
// The reference model tracks words in flight as a queue of {data, position}:
// the oldest word leaves when it sits at the last position and downstream
// accepts, each word then steps forward if the slot ahead is free, and a new
// word enters when position 0 ends up free.
module tb_dut_pipe;

    localparam int unsigned W    = 8;
    localparam int unsigned CH   = 2;
    localparam int unsigned D    = 4;
    localparam int unsigned CW   = 3;
    localparam int unsigned DW   = W * CH;
    localparam int          CMAX = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [2:0]    occupancy;
    logic [CW-1:0] xfer_count;

    dut_pipe #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D), .CNT_W(CW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            pos;
    } ent_t;

    ent_t          mq[$];
    int            mcnt;
    bit            exp_ir;
    bit            exp_ov;
    logic [DW-1:0] exp_od;
    int            errors = 0;
    int            checks = 0;

    function automatic void model_reset();
        mq.delete();
        mcnt = 0;
    endfunction

    // Expected handshake outputs for this cycle, then the state after the edge.
    function automatic void model_step(input bit iv, input logic [DW-1:0] id,
                                       input bit ordy, input bit fl);
        int   limit;
        ent_t e;
        exp_ov = !fl && (mq.size() > 0) && (mq[0].pos == int'(D) - 1);
        exp_od = (mq.size() > 0) ? mq[0].d : '0;
        if (fl) begin
            exp_ir = 1'b0;
            mq.delete();
            return;
        end
        if (exp_ov && ordy) begin
            void'(mq.pop_front());
            if (mcnt < CMAX) mcnt++;
        end
        limit = int'(D);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].pos + 1 < limit) mq[i].pos = mq[i].pos + 1;
            limit = mq[i].pos;
        end
        exp_ir = (limit > 0);
        if (exp_ir && iv) begin
            e.d   = id;
            e.pos = 0;
            mq.push_back(e);
        end
    endfunction

    task automatic drive(input bit iv, input logic [DW-1:0] id, input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        model_step(iv, id, ordy, fl);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1; flush = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ov c%0d: got %b exp 0", c, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ir c%0d: got %b exp 0", c, in_ready); end
        end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occ: got %0d exp 0", occupancy); end
        checks++; if (xfer_count !== 3'd0) begin errors++; $display("FAIL rst_cnt: got %0d exp 0", xfer_count); end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
            checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_rel_occ c%0d: got %0d exp 0", c, occupancy); end
        end
    endtask

    task automatic test_latency();
        do_reset();
        drive(1'b1, 16'hA55A, 1'b1, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_ir: got %b exp 1", in_ready); end
        tick();
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_ov j%0d: got %b exp 0", j, out_valid); end
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_ov: got %b exp 1", out_valid); end
        checks++; if (out_data !== 16'hA55A) begin errors++; $display("FAIL lat_data: got %h exp a55a", out_data); end
        tick();
        checks++; if (xfer_count !== 3'd1) begin errors++; $display("FAIL lat_cnt: got %0d exp 1", xfer_count); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL lat_occ: got %0d exp 0", occupancy); end
    endtask

    task automatic test_backpressure();
        int            idx;
        logic [DW-1:0] rx[$];
        do_reset();
        idx = 1;
        for (int c = 0; c < 6; c++) begin
            drive(idx <= 6, 16'(idx), 1'b0, 1'b0);
            if (exp_ir && idx <= 6) idx++;
            tick();
        end
        checks++; if (idx !== 5) begin errors++; $display("FAIL bp_accepted: got %0d exp 4", idx - 1); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occ: got %0d exp 4", occupancy); end
        drive(1'b1, 16'(idx), 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ir: got %b exp 0", in_ready); end
        tick();
        for (int c = 0; c < 30 && rx.size() < 6; c++) begin
            drive(idx <= 6, 16'(idx), 1'b1, 1'b0);
            if (out_valid === 1'b1) rx.push_back(out_data);
            if (exp_ir && idx <= 6) idx++;
            tick();
        end
        checks++; if (rx.size() !== 6) begin errors++; $display("FAIL bp_rx_count: got %0d exp 6", rx.size()); end
        for (int i = 0; i < rx.size(); i++) begin
            checks++; if (rx[i] !== 16'(i + 1)) begin errors++; $display("FAIL bp_rx%0d: got %h exp %h", i, rx[i], 16'(i + 1)); end
        end
        checks++; if (xfer_count !== 3'd6) begin errors++; $display("FAIL bp_cnt: got %0d exp 6", xfer_count); end
        for (int c = 0; c < 3; c++) begin drive(1'b0, '0, 1'b1, 1'b0); tick(); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got out_valid %b exp 0", out_valid); end
    endtask

    task automatic test_bubble();
        do_reset();
        drive(1'b1, 16'h0011, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_ir0: got %b exp 1", in_ready); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h0022, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_ir2: got %b exp 1", in_ready); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_stall_ir c%0d: got %b exp 1", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_data !== 16'h0011) begin
                errors++; $display("FAIL bub_stall_out c%0d: got %b/%h exp 1/0011", c, out_valid, out_data); end
            tick();
        end
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL bub_occ: got %0d exp 2", occupancy); end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0011) begin
            errors++; $display("FAIL bub_out0: got %b/%h exp 1/0011", out_valid, out_data); end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0022) begin
            errors++; $display("FAIL bub_out1: got %b/%h exp 1/0022", out_valid, out_data); end
        tick();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL bub_occ_end: got %0d exp 0", occupancy); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 16'h0F0F, 1'b1, 1'b0); tick();
        for (int c = 0; c < 5; c++) begin drive(1'b0, '0, 1'b1, 1'b0); tick(); end
        for (int w = 0; w < 4; w++) begin drive(1'b1, 16'(16'h31 + w), 1'b0, 1'b0); tick(); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fl_full: got %0d exp 4", occupancy); end
        drive(1'b1, 16'h0099, 1'b1, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_ir: got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_ov: got %b exp 0", out_valid); end
        tick();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fl_occ: got %0d exp 0", occupancy); end
        checks++; if (xfer_count !== 3'd1) begin errors++; $display("FAIL fl_cnt: got %0d exp 1", xfer_count); end
        drive(1'b1, 16'h0077, 1'b1, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_post_ir: got %b exp 1", in_ready); end
        tick();
        for (int j = 0; j < 3; j++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_post_early j%0d: got %b exp 0", j, out_valid); end
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h0077) begin
            errors++; $display("FAIL fl_post_out: got %b/%h exp 1/0077", out_valid, out_data); end
        tick();
    endtask

    task automatic test_saturation();
        int idx;
        int n_out;
        do_reset();
        idx = 0; n_out = 0;
        for (int c = 0; c < 40 && n_out < 10; c++) begin
            drive(1'b1, 16'(16'h0100 + idx), 1'b1, 1'b0);
            if (exp_ir) idx++;
            if (out_valid === 1'b1) n_out++;
            tick();
        end
        checks++; if (n_out !== 10) begin errors++; $display("FAIL sat_nout: got %0d exp 10", n_out); end
        checks++; if (xfer_count !== 3'd7) begin errors++; $display("FAIL sat_cnt: got %0d exp 7", xfer_count); end
        drive(1'b1, 16'h0BAD, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_ov: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mrst_ir: got %b exp 0", in_ready); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL mrst_occ: got %0d exp 0", occupancy); end
        checks++; if (xfer_count !== 3'd0) begin errors++; $display("FAIL mrst_cnt: got %0d exp 0", xfer_count); end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        drive(1'b1, 16'h0C0C, 1'b1, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL mrst_restart_ov c%0d: got %b exp %b", c, out_valid, exp_ov); end
            if (exp_ov) begin
                checks++; if (out_data !== 16'h0C0C) begin errors++; $display("FAIL mrst_restart_data: got %h exp 0c0c", out_data); end
            end
            tick();
        end
        checks++; if (xfer_count !== 3'd1) begin errors++; $display("FAIL mrst_restart_cnt: got %0d exp 1", xfer_count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bit            iv;
            bit            ordy;
            bit            fl;
            logic [DW-1:0] id;
            iv   = ($urandom_range(0, 3) != 0);
            id   = 16'($urandom);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 24) == 0);
            drive(iv, id, ordy, fl);
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL rnd_ir c%0d: got %b exp %b", c, in_ready, exp_ir); end
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_ov c%0d: got %b exp %b", c, out_valid, exp_ov); end
            if (exp_ov) begin
                checks++; if (out_data !== exp_od) begin errors++; $display("FAIL rnd_data c%0d: got %h exp %h", c, out_data, exp_od); end
            end
            tick();
            checks++; if (occupancy !== 3'(mq.size())) begin errors++; $display("FAIL rnd_occ c%0d: got %0d exp %0d", c, occupancy, mq.size()); end
            checks++; if (xfer_count !== 3'(mcnt)) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d exp %0d", c, xfer_count, mcnt); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_bubble();
        test_flush();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
